// File: rtl/video_clken_gen_if.sv
// rtl/video_clken_gen_if.sv - config request/response interface for video_clken_gen
interface video_clken_gen_if #(
  parameter int ACC_W = 16,
  parameter int CH_W  = 4
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [ACC_W-1:0] cfg_num;
  logic [ACC_W-1:0] cfg_den;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_chan, cfg_num, cfg_den,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_num, cfg_den,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/video_clken_gen.sv
// rtl/video_clken_gen.sv - N-channel fractional clock-enable generator with settle/lock FSM
module video_clken_gen #(
  parameter int                          NUM_CLOCKS  = 3,
  parameter int                          ACC_W       = 16,
  parameter int                          CH_W        = 4,
  parameter int                          LOCK_CYCLES = 1024,
  parameter logic [NUM_CLOCKS*ACC_W-1:0] INIT_NUM    = {16'd33, 16'd1, 16'd1},
  parameter logic [NUM_CLOCKS*ACC_W-1:0] INIT_DEN    = {16'd50, 16'd2, 16'd2}
) (
  input  logic                  refclk,
  input  logic                  rst,
  video_clken_gen_if.slave      cfg,
  output logic [NUM_CLOCKS-1:0] en_out,
  output logic                  locked
);

  localparam int               CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CH_W:0]    NUM_CH   = (CH_W + 1)'(NUM_CLOCKS);

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;
  logic             req_ok;
  logic             cfg_take;
  logic             cfg_bad;
  logic             cfg_ready_c;
  logic             cfg_err_q;
  logic             run;

  // A request is only legal for an existing channel with 0 < num <= den.
  assign req_ok = ({1'b0, cfg.cfg_chan} < NUM_CH) &&
                  (cfg.cfg_num != '0) && (cfg.cfg_den != '0) &&
                  (cfg.cfg_num <= cfg.cfg_den);

  assign cnt_done      = (cnt == CNT_LAST);
  assign run           = (state == LOCKED) && !cfg_take;
  assign cfg.cfg_ready = cfg_ready_c;
  assign cfg.cfg_err   = cfg_err_q;

  // FSM state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) state <= SETTLE;
    else     state <= state_nxt;
  end

  // Next-state decode, lock/ready outputs and config accept/reject strobes.
  always_comb begin
    state_nxt   = state;
    locked      = 1'b0;
    cfg_ready_c = 1'b0;
    cfg_take    = 1'b0;
    cfg_bad     = 1'b0;
    case (state)
      SETTLE: begin
        if (cnt_done) state_nxt = LOCKED;
      end
      LOCKED: begin
        locked      = 1'b1;
        cfg_ready_c = 1'b1;
        if (cfg.cfg_valid) begin
          if (req_ok) begin
            cfg_take  = 1'b1;
            state_nxt = SETTLE;
          end else begin
            cfg_bad = 1'b1;
          end
        end
      end
      default: state_nxt = SETTLE;
    endcase
  end

  // Settle counter: counts only while settling, cleared on the way into LOCKED.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (state == SETTLE)  cnt <= cnt_done ? '0 : cnt + 1'b1;
    else                       cnt <= '0;
  end

  // Rejected requests produce a single-cycle error pulse.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) cfg_err_q <= 1'b0;
    else     cfg_err_q <= cfg_bad;
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] num_r;
    logic [ACC_W-1:0] den_r;
    logic             en_q;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] wrap;
    logic             hit;

    // One extra bit keeps acc + num exact; after wrap the result is < den so it fits ACC_W.
    assign sum       = {1'b0, acc} + {1'b0, num_r};
    assign hit       = (sum >= {1'b0, den_r});
    assign wrap      = sum[ACC_W-1:0] - den_r;
    assign en_out[i] = en_q;

    // Ratio registers: INIT values on reset, overwritten only by an accepted request for this channel.
    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        num_r <= INIT_NUM[i*ACC_W +: ACC_W];
        den_r <= INIT_DEN[i*ACC_W +: ACC_W];
      end else if (cfg_take && (cfg.cfg_chan == CH_W'(i))) begin
        num_r <= cfg.cfg_num;
        den_r <= cfg.cfg_den;
      end
    end

    // Phase accumulator: held at zero outside LOCKED so all channels restart aligned.
    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        acc  <= '0;
        en_q <= 1'b0;
      end else if (!run) begin
        acc  <= '0;
        en_q <= 1'b0;
      end else if (hit) begin
        acc  <= wrap;
        en_q <= 1'b1;
      end else begin
        acc  <= sum[ACC_W-1:0];
        en_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_clken_gen.sv
// tb/tb_video_clken_gen.sv - self-checking bench for video_clken_gen
module tb_video_clken_gen;

  localparam int NCH  = 3;
  localparam int LOCK = 16;

  logic           refclk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en_out;
  logic           locked;

  video_clken_gen_if #(.ACC_W(16), .CH_W(4)) cfg_if ();

  video_clken_gen #(
    .NUM_CLOCKS (NCH),
    .ACC_W      (16),
    .CH_W       (4),
    .LOCK_CYCLES(LOCK),
    .INIT_NUM   ({16'd33, 16'd1, 16'd1}),
    .INIT_DEN   ({16'd50, 16'd2, 16'd2})
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .cfg   (cfg_if),
    .en_out(en_out),
    .locked(locked)
  );

  always #5 refclk = ~refclk;

  int checks   = 0;
  int failures = 0;
  int m_num[NCH];
  int m_den[NCH];
  int lk;

  // Reference: channel fires on LOCKED edge k iff floor(k*num/den) steps up.
  function automatic logic [NCH-1:0] exp_en(input int k);
    logic [NCH-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++)
      if (k >= 1)
        v[c] = ((longint'(k) * m_num[c]) / m_den[c]) != ((longint'(k - 1) * m_num[c]) / m_den[c]);
    return v;
  endfunction

  task automatic model_init();
    m_num = '{1, 1, 33};
    m_den = '{2, 2, 50};
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic send_cfg(input int ch, input int n, input int d);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = 4'(ch);
    cfg_if.cfg_num   = 16'(n);
    cfg_if.cfg_den   = 16'(d);
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_settle(input string tag);
    for (int e = 0; e < LOCK; e++) begin
      checks++;
      if (locked !== 1'b0 || en_out !== '0 || cfg_if.cfg_ready !== 1'b0 || cfg_if.cfg_err !== 1'b0) begin
        failures++;
        $display("FAIL %s settle cycle %0d: locked=%b en_out=%b ready=%b err=%b, want 0 000 0 0",
                 tag, e, locked, en_out, cfg_if.cfg_ready, cfg_if.cfg_err);
      end
      tick();
    end
    checks++;
    if (locked !== 1'b1 || cfg_if.cfg_ready !== 1'b1 || en_out !== '0) begin
      failures++;
      $display("FAIL %s lock: locked=%b ready=%b en_out=%b, want 1 1 000",
               tag, locked, cfg_if.cfg_ready, en_out);
    end
    lk = 0;
  endtask

  task automatic test_pattern(input string tag, input int n);
    repeat (n) begin
      tick();
      lk++;
      checks++;
      if (en_out !== exp_en(lk) || locked !== 1'b1) begin
        failures++;
        $display("FAIL %s pattern lk=%0d: en_out=%b locked=%b, want en_out=%b locked=1",
                 tag, lk, en_out, locked, exp_en(lk));
      end
    end
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_chan  = '0;
    cfg_if.cfg_num   = '0;
    cfg_if.cfg_den   = '0;
    #3;
    repeat (3) @(posedge refclk);
    #1;
    checks++;
    if (locked !== 1'b0 || en_out !== '0 || cfg_if.cfg_ready !== 1'b0 || cfg_if.cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: locked=%b en_out=%b ready=%b err=%b, want 0 000 0 0",
               locked, en_out, cfg_if.cfg_ready, cfg_if.cfg_err);
    end
    rst = 1'b0;
    model_init();
    test_settle("reset");
  endtask

  task automatic test_default();
    logic h[60];
    int   off;
    int   cnt;
    test_pattern("default", 10);
    for (int i = 0; i < 60; i++) begin
      test_pattern("default_win", 1);
      h[i] = en_out[2];
    end
    off = $urandom_range(0, 9);
    cnt = 0;
    for (int i = 0; i < 50; i++) cnt += int'(h[off + i]);
    checks++;
    if (cnt != 33) begin
      failures++;
      $display("FAIL ch2_window: pulses=%0d in 50 cycles, want 33", cnt);
    end
  endtask

  task automatic test_reconfig();
    send_cfg(1, 1, 4);
    m_num[1] = 1;
    m_den[1] = 4;
    test_settle("reconfig");
    test_pattern("reconfig", 24);
  endtask

  task automatic test_invalid();
    int chs[4] = '{3, 1, 1, 0};
    int ns[4]  = '{1, 0, 1, 5};
    int ds[4]  = '{2, 2, 0, 4};
    int ch, n, d;
    for (int t = 0; t < 8; t++) begin
      if (t < 4) begin
        ch = chs[t]; n = ns[t]; d = ds[t];
      end else if ($urandom_range(0, 1) == 1) begin
        ch = $urandom_range(3, 15); d = $urandom_range(1, 20); n = $urandom_range(1, d);
      end else begin
        ch = $urandom_range(0, 2); n = $urandom_range(2, 20); d = $urandom_range(1, n - 1);
      end
      send_cfg(ch, n, d);
      lk++;
      checks++;
      if (cfg_if.cfg_err !== 1'b1 || locked !== 1'b1 || en_out !== exp_en(lk)) begin
        failures++;
        $display("FAIL invalid%0d pulse (ch=%0d n=%0d d=%0d): err=%b locked=%b en_out=%b, want 1 1 %b",
                 t, ch, n, d, cfg_if.cfg_err, locked, en_out, exp_en(lk));
      end
      tick();
      lk++;
      checks++;
      if (cfg_if.cfg_err !== 1'b0 || locked !== 1'b1 || en_out !== exp_en(lk)) begin
        failures++;
        $display("FAIL invalid%0d after: err=%b locked=%b en_out=%b, want 0 1 %b",
                 t, cfg_if.cfg_err, locked, en_out, exp_en(lk));
      end
      test_pattern("invalid", 3);
    end
  endtask

  task automatic test_unity();
    send_cfg(0, 7, 7);
    m_num[0] = 7;
    m_den[0] = 7;
    test_settle("unity");
    test_pattern("unity", 20);
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (en_out !== '0 || locked !== 1'b0 || cfg_if.cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_rst_locked: en_out=%b locked=%b ready=%b, want 000 0 0",
               en_out, locked, cfg_if.cfg_ready);
    end
    @(posedge refclk);
    #1;
    rst = 1'b0;
    model_init();
    test_settle("async_rst1");
    send_cfg(1, 1, 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (locked !== 1'b0) begin
        failures++;
        $display("FAIL async_settle%0d: locked=%b, want 0", i, locked);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (en_out !== '0 || locked !== 1'b0 || cfg_if.cfg_ready !== 1'b0 || cfg_if.cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL async_rst_settle: en_out=%b locked=%b ready=%b err=%b, want 000 0 0 0",
               en_out, locked, cfg_if.cfg_ready, cfg_if.cfg_err);
    end
    repeat (2) @(posedge refclk);
    #1;
    rst = 1'b0;
    model_init();
    test_settle("async_rst2");
    test_pattern("async_init", 12);
  endtask

  task automatic test_random_reconfig();
    int ch, n, d;
    for (int t = 0; t < 3; t++) begin
      ch = $urandom_range(0, 2);
      d  = $urandom_range(1, 12);
      n  = $urandom_range(1, d);
      send_cfg(ch, n, d);
      m_num[ch] = n;
      m_den[ch] = d;
      test_settle("rand_cfg");
      test_pattern("rand_cfg", 30);
    end
  endtask

  task automatic test_handshake_hold();
    send_cfg(2, 3, 5);
    m_num[2] = 3;
    m_den[2] = 5;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = 4'd0;
    cfg_if.cfg_num   = 16'd2;
    cfg_if.cfg_den   = 16'd3;
    test_settle("hold_settle");
    tick();
    cfg_if.cfg_valid = 1'b0;
    m_num[0] = 2;
    m_den[0] = 3;
    test_settle("hold_accept");
    test_pattern("hold_after", 15);
  endtask

  initial begin
    test_reset();
    test_default();
    test_reconfig();
    test_invalid();
    test_unity();
    test_async_reset();
    test_random_reconfig();
    test_handshake_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_clken_gen.md
Name: video_clken_gen

Overview:
- Parametrised, N-channel fractional clock-enable generator for the VGA subsystem.
- Successor to the fixed 3-output video PLL wrapper. Each channel emits a single-cycle enable at average rate refclk*NUM/DEN instead of a dedicated clock.
- Ratios are reprogrammable at run time through a valid/ready config port. A settle interval gates the `locked` output.
- All channels restart phase-aligned after reset and after every accepted reconfiguration.

Parameters:
- NUM_CLOCKS, 3, number of enable channels (1..16).
- ACC_W, 16, width of NUM, DEN and each phase accumulator.
- CH_W, 4, width of cfg_chan.
- LOCK_CYCLES, 1024, settle cycles before `locked` asserts (>=1).
- INIT_NUM, {16'd33,16'd1,16'd1}, packed NUM_CLOCKS*ACC_W reset numerators; channel 0 in the LSBs.
- INIT_DEN, {16'd50,16'd2,16'd2}, packed NUM_CLOCKS*ACC_W reset denominators.

Ports:
- refclk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config port can accept a request.
- cfg_chan  in  CH_W  target channel.
- cfg_num  in  ACC_W  new numerator.
- cfg_den  in  ACC_W  new denominator.
- cfg_err  out  1  one-cycle pulse: request rejected.
- en_out  out  NUM_CLOCKS  per-channel clock-enable pulses.
- locked  out  1  all channels running with current configuration.

Behaviour:

Reset values (rst high, asynchronous):
- acc[i]=0; num[i]/den[i] = INIT values.
- en_out=0, locked=0, cfg_ready=0, cfg_err=0.
- lock counter=0; FSM=SETTLE.
- Reset mid-operation discards any runtime config and reverts to INIT values.

FSM, two states:
- SETTLE
  - acc held at 0; en_out forced 0; locked=0; cfg_ready=0; counter increments each cycle.
  - When counter reaches LOCK_CYCLES-1, go to LOCKED and clear the counter.
  - `locked` rises exactly LOCK_CYCLES cycles after the first refclk edge with rst low, or after the accepting edge.
- LOCKED
  - locked=1, cfg_ready=1; accumulators run.

Accumulator, per channel per LOCKED cycle:
- sum = acc + num, computed at ACC_W+1 bits.
- If sum >= den: acc <= sum - den and en_out[i] <= 1.
- Else: acc <= sum and en_out[i] <= 0.
- en_out is registered; no overflow is possible because acc < den and num <= den.
- num == den gives en_out high every LOCKED cycle after the first.

Config handshake:
- A request is accepted on a cycle with cfg_valid && cfg_ready. Inputs are sampled at that edge.
- A request is valid iff cfg_chan < NUM_CLOCKS, num != 0, den != 0 and num <= den.
- Invalid request:
  - cfg_err=1 for the following cycle only.
  - FSM stays LOCKED; no state changes; accumulators keep running.
- Valid request:
  - num/den of the channel are updated.
  - Next cycle: FSM=SETTLE, locked=0, cfg_ready=0, all acc=0, en_out=0. Every channel is re-aligned, not only the target.
- cfg_valid while cfg_ready=0 is ignored, not queued. The requester must hold it until accepted.
- Back-to-back valid requests are impossible: cfg_ready drops for the whole settle interval.
- rst asserted during SETTLE aborts the settle and restores INIT values.

Test Plan:
- Reset, defaults, LOCK_CYCLES=16: release rst.
  - locked=0 and en_out=0 for 16 cycles, then locked=1.
  - Ch0 and ch1 (1/2): en_out high on the 2nd LOCKED edge, then every 2 cycles.
  - Ch2 (33/50): exactly 33 pulses in any 50-cycle window after lock.
- Valid reconfiguration: cfg_chan=1, num=1, den=4.
  - Next cycle: cfg_ready=0, locked=0, en_out=0.
  - Relock after 16 cycles; ch1 then pulses on LOCKED cycles 4, 8, 12, ...
  - Ch0 and ch2 restart from phase 0.
- Invalid requests: (chan=3), (num=0), (den=0) and (num=5, den=4), each sent separately.
  - Each gives a single-cycle cfg_err pulse; locked stays 1.
  - en_out pattern continues unbroken.
- num=den=7 on ch0: en_out[0] constantly high from the 2nd LOCKED cycle onward.
- Async reset mid-settle: assert rst 5 cycles into SETTLE after a reconfig.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, ch1 runs at INIT ratio 1/2.
- Handshake hold: assert cfg_valid during SETTLE and hold it.
  - Accepted on the first LOCKED cycle.
  - No cfg_err pulse and no duplicate acceptance.
